// File: rtl/snoop_bus_arb_if.sv
// Snoop bus bundle between the per-core miss requesters and the snoop arbiter.
// master = core/memory side, slave = arbiter.
interface snoop_bus_arb_if #(
  parameter int NUM_CPU = 4,
  parameter int TAG_W   = 16
);
  logic [NUM_CPU-1:0]       read_miss;
  logic [NUM_CPU-1:0]       write_miss;
  logic [NUM_CPU-1:0]       write_miss_state;
  logic [NUM_CPU*TAG_W-1:0] req_tag;
  logic [NUM_CPU-1:0]       cpu_search_found;
  logic                     mem_ack;
  logic [TAG_W-1:0]         tag_out;
  logic [NUM_CPU-1:0]       cpu_search;
  logic [NUM_CPU-1:0]       cpu_datasel;
  logic [NUM_CPU-1:0]       cpu_doing_curr_op;
  logic                     invalidate;
  logic                     mem_re;
  logic [NUM_CPU-1:0]       op_done;

  modport master (
    output read_miss, write_miss, write_miss_state, req_tag, cpu_search_found, mem_ack,
    input  tag_out, cpu_search, cpu_datasel, cpu_doing_curr_op, invalidate, mem_re, op_done
  );
  modport slave (
    input  read_miss, write_miss, write_miss_state, req_tag, cpu_search_found, mem_ack,
    output tag_out, cpu_search, cpu_datasel, cpu_doing_curr_op, invalidate, mem_re, op_done
  );
endinterface

// File: rtl/snoop_bus_arb.sv
// Snoop bus arbiter: grants one core's miss, snoops peers, falls back to memory.
// Define SNOOP_RR_ARB_EN for round-robin arbitration (default: fixed priority, lowest index).
module snoop_bus_arb #(
  parameter int NUM_CPU = 4,
  parameter int TAG_W   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  snoop_bus_arb_if.slave  bus
);
  localparam int IDX_W = (NUM_CPU > 1) ? $clog2(NUM_CPU) : 1;

  typedef enum logic [2:0] {IDLE, SEARCH, RESP, MEM, DONE} state_t;
  state_t state, state_nx;

  logic [NUM_CPU-1:0] req, arb_oh, gnt, found_m, hit_oh;
  logic [IDX_W-1:0]   arb_idx;
  logic [TAG_W-1:0]   tag_q;
  logic               is_wr, is_upg;
  logic [NUM_CPU-1:0] search_nx, dsel_nx, doing_nx, done_nx;
  logic               inv_nx, mem_re_nx;
`ifdef SNOOP_RR_ARB_EN
  logic [IDX_W-1:0]   ptr, gnt_idx;
`endif

  assign req     = bus.read_miss | bus.write_miss;
  assign found_m = bus.cpu_search_found & ~gnt;
  assign arb_oh  = NUM_CPU'(1) << arb_idx;
  assign bus.tag_out = tag_q;

  // descending scan, last match wins -> first requester from the start index
  always_comb begin
    int i;
    i = 0;
    arb_idx = '0;
    for (int k = NUM_CPU-1; k >= 0; k--) begin
`ifdef SNOOP_RR_ARB_EN
      i = int'(ptr) + k;
      if (i >= NUM_CPU) i = i - NUM_CPU;
`else
      i = k;
`endif
      if (req[IDX_W'(i)]) arb_idx = IDX_W'(i);
    end
  end

  always_comb begin
    hit_oh = '0;
    for (int k = NUM_CPU-1; k >= 0; k--)
      if (found_m[k]) hit_oh = NUM_CPU'(1) << k;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|req) state_nx = SEARCH;
      SEARCH:  state_nx = RESP;
      RESP:    state_nx = ((is_wr && is_upg) || (|found_m)) ? DONE : MEM;
      MEM:     if (bus.mem_ack) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // output registers are loaded from the next state so they line up with it
    search_nx = (state_nx == SEARCH) ? ~arb_oh : '0;
    inv_nx    = (state_nx == SEARCH) && bus.write_miss[arb_idx];
    doing_nx  = (state_nx == IDLE) ? '0 : ((state == IDLE) ? arb_oh : gnt);
    dsel_nx   = (state == RESP && state_nx == DONE && !(is_wr && is_upg)) ? hit_oh : '0;
    mem_re_nx = (state_nx == MEM);
    done_nx   = (state_nx == DONE) ? gnt : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= IDLE;
      gnt                   <= '0;
      tag_q                 <= '0;
      is_wr                 <= 1'b0;
      is_upg                <= 1'b0;
      bus.cpu_search        <= '0;
      bus.cpu_datasel       <= '0;
      bus.cpu_doing_curr_op <= '0;
      bus.invalidate        <= 1'b0;
      bus.mem_re            <= 1'b0;
      bus.op_done           <= '0;
`ifdef SNOOP_RR_ARB_EN
      ptr                   <= '0;
      gnt_idx               <= '0;
`endif
    end else begin
      state                 <= state_nx;
      bus.cpu_search        <= search_nx;
      bus.cpu_datasel       <= dsel_nx;
      bus.cpu_doing_curr_op <= doing_nx;
      bus.invalidate        <= inv_nx;
      bus.mem_re            <= mem_re_nx;
      bus.op_done           <= done_nx;
      if (state == IDLE && state_nx == SEARCH) begin
        gnt    <= arb_oh;
        tag_q  <= bus.req_tag[arb_idx*TAG_W +: TAG_W];
        is_wr  <= bus.write_miss[arb_idx];
        is_upg <= bus.write_miss_state[arb_idx];
`ifdef SNOOP_RR_ARB_EN
        gnt_idx <= arb_idx;
`endif
      end
`ifdef SNOOP_RR_ARB_EN
      if (state == DONE)
        ptr <= (gnt_idx == IDX_W'(NUM_CPU-1)) ? '0 : gnt_idx + 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_snoop_bus_arb.sv
// Scoreboard bench for snoop_bus_arb: expected completions queued at stimulus, checked at op_done.
module tb_snoop_bus_arb;
  localparam int N  = 4;
  localparam int TW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snoop_bus_arb_if #(.NUM_CPU(N), .TAG_W(TW)) bus();
  snoop_bus_arb #(.NUM_CPU(N), .TAG_W(TW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [N-1:0]  done;
    logic [N-1:0]  dsel;
    logic [N-1:0]  search;
    logic          inv;
    int            lat;
    int            mem;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t sbq[$];
  int errors = 0;
  int checks = 0;

  int            o_lat, o_mem;
  logic [N-1:0]  o_search, o_doing, o_dsel, o_done;
  logic          o_inv;
  logic [TW-1:0] o_tag;

  task automatic clear_req;
    bus.read_miss = '0;
    bus.write_miss = '0;
    bus.write_miss_state = '0;
    bus.req_tag = '0;
    bus.cpu_search_found = '0;
  endtask

  // drive one miss, answer mem_re after ack_delay mem cycles, record observations
  task automatic do_op(input logic [1:0] core, input bit rd, input bit wr, input bit wms,
                       input logic [TW-1:0] tag, input logic [N-1:0] found,
                       input int ack_delay, input bit settle, input bit drop_early);
    int mcnt;
    bit fin;
    if (settle) @(negedge clk);
    bus.read_miss[core] = rd;
    bus.write_miss[core] = wr;
    bus.write_miss_state[core] = wms;
    bus.req_tag[core*TW +: TW] = tag;
    bus.cpu_search_found = found;
    o_lat = -1; o_mem = 0; o_dsel = '0; o_done = '0; mcnt = 0; fin = 0;
    for (int c = 1; c <= 40 && !fin; c++) begin
      @(negedge clk);
      if (c == 1) begin
        o_search = bus.cpu_search;
        o_inv    = bus.invalidate;
        o_doing  = bus.cpu_doing_curr_op;
        o_tag    = bus.tag_out;
        if (drop_early) begin
          bus.read_miss = '0;
          bus.write_miss = '0;
        end
      end
      o_dsel |= bus.cpu_datasel;
      if (bus.mem_re) begin
        o_mem++;
        mcnt++;
        if (mcnt == ack_delay) bus.mem_ack = 1'b1;
      end
      if (bus.op_done != '0) begin
        o_lat = c;
        o_done = bus.op_done;
        fin = 1;
      end
    end
    bus.mem_ack = 1'b0;
    clear_req();
  endtask

  task automatic test_reset;
    logic [4*N+2+TW-1:0] outs;
    clear_req();
    bus.mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    outs = {bus.cpu_search, bus.cpu_datasel, bus.cpu_doing_curr_op, bus.op_done,
            bus.invalidate, bus.mem_re, bus.tag_out};
    checks++; if (outs !== '0) begin errors++; $display("FAIL reset_outs got=%h exp=0", outs); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.cpu_doing_curr_op !== '0) begin errors++; $display("FAIL reset_idle_doing got=%b exp=0000", bus.cpu_doing_curr_op); end
    checks++; if (bus.mem_re !== 1'b0) begin errors++; $display("FAIL reset_idle_mem_re got=%b exp=0", bus.mem_re); end
  endtask

  task automatic test_peer_hit;
    exp_t g;
    sbq.push_back('{done:4'b0100, dsel:4'b0001, search:4'b1011, inv:1'b0, lat:3, mem:0, tag:16'h1234});
    do_op(2'd2, 1, 0, 0, 16'h1234, 4'b0001, 0, 1, 0);
    g = sbq.pop_front();
    checks++; if (o_search !== g.search) begin errors++; $display("FAIL hit_search got=%b exp=%b", o_search, g.search); end
    checks++; if (o_doing !== g.done) begin errors++; $display("FAIL hit_doing got=%b exp=%b", o_doing, g.done); end
    checks++; if (o_tag !== g.tag) begin errors++; $display("FAIL hit_tag got=%h exp=%h", o_tag, g.tag); end
    checks++; if (o_dsel !== g.dsel) begin errors++; $display("FAIL hit_datasel got=%b exp=%b", o_dsel, g.dsel); end
    checks++; if (o_done !== g.done) begin errors++; $display("FAIL hit_done got=%b exp=%b", o_done, g.done); end
    checks++; if (o_lat !== g.lat) begin errors++; $display("FAIL hit_latency got=%0d exp=%0d", o_lat, g.lat); end
    checks++; if (o_mem !== g.mem) begin errors++; $display("FAIL hit_mem_re got=%0d exp=%0d", o_mem, g.mem); end
  endtask

  task automatic test_upgrade;
    exp_t g;
    sbq.push_back('{done:4'b0010, dsel:4'b0000, search:4'b1101, inv:1'b1, lat:3, mem:0, tag:16'hA5A5});
    do_op(2'd1, 0, 1, 1, 16'hA5A5, 4'b1111, 0, 1, 0);
    g = sbq.pop_front();
    checks++; if (o_inv !== g.inv) begin errors++; $display("FAIL upg_invalidate got=%b exp=%b", o_inv, g.inv); end
    checks++; if (o_dsel !== g.dsel) begin errors++; $display("FAIL upg_datasel got=%b exp=%b", o_dsel, g.dsel); end
    checks++; if (o_mem !== g.mem) begin errors++; $display("FAIL upg_mem_re got=%0d exp=%0d", o_mem, g.mem); end
    checks++; if (o_done !== g.done) begin errors++; $display("FAIL upg_done got=%b exp=%b", o_done, g.done); end
    checks++; if (o_lat !== g.lat) begin errors++; $display("FAIL upg_latency got=%0d exp=%0d", o_lat, g.lat); end
  endtask

  task automatic test_mem_fill;
    exp_t g;
    sbq.push_back('{done:4'b1000, dsel:4'b0000, search:4'b0111, inv:1'b0, lat:8, mem:5, tag:16'h0F0F});
    do_op(2'd3, 1, 0, 0, 16'h0F0F, 4'b0000, 5, 1, 0);
    g = sbq.pop_front();
    checks++; if (o_search !== g.search) begin errors++; $display("FAIL mem_search got=%b exp=%b", o_search, g.search); end
    checks++; if (o_mem !== g.mem) begin errors++; $display("FAIL mem_re_cycles got=%0d exp=%0d", o_mem, g.mem); end
    checks++; if (o_lat !== g.lat) begin errors++; $display("FAIL mem_latency got=%0d exp=%0d", o_lat, g.lat); end
    checks++; if (o_done !== g.done) begin errors++; $display("FAIL mem_done got=%b exp=%b", o_done, g.done); end
  endtask

  task automatic test_own_found;
    exp_t g;
    sbq.push_back('{done:4'b0010, dsel:4'b0000, search:4'b1101, inv:1'b0, lat:5, mem:2, tag:16'h0042});
    do_op(2'd1, 1, 0, 0, 16'h0042, 4'b0010, 2, 1, 0);
    g = sbq.pop_front();
    checks++; if (o_mem !== g.mem) begin errors++; $display("FAIL own_mem_re got=%0d exp=%0d", o_mem, g.mem); end
    checks++; if (o_dsel !== g.dsel) begin errors++; $display("FAIL own_datasel got=%b exp=%b", o_dsel, g.dsel); end
    checks++; if (o_lat !== g.lat) begin errors++; $display("FAIL own_latency got=%0d exp=%0d", o_lat, g.lat); end
  endtask

  task automatic test_rw_both;
    exp_t g;
    sbq.push_back('{done:4'b0001, dsel:4'b0100, search:4'b1110, inv:1'b1, lat:3, mem:0, tag:16'hC0DE});
    do_op(2'd0, 1, 1, 0, 16'hC0DE, 4'b0100, 0, 1, 0);
    g = sbq.pop_front();
    checks++; if (o_inv !== g.inv) begin errors++; $display("FAIL rw_invalidate got=%b exp=%b", o_inv, g.inv); end
    checks++; if (o_dsel !== g.dsel) begin errors++; $display("FAIL rw_datasel got=%b exp=%b", o_dsel, g.dsel); end
    checks++; if (o_done !== g.done) begin errors++; $display("FAIL rw_done got=%b exp=%b", o_done, g.done); end
  endtask

  task automatic test_no_abort;
    exp_t g;
    sbq.push_back('{done:4'b0100, dsel:4'b1000, search:4'b1011, inv:1'b0, lat:3, mem:0, tag:16'h7777});
    do_op(2'd2, 1, 0, 0, 16'h7777, 4'b1000, 0, 1, 1);
    g = sbq.pop_front();
    checks++; if (o_done !== g.done) begin errors++; $display("FAIL abort_done got=%b exp=%b", o_done, g.done); end
    checks++; if (o_lat !== g.lat) begin errors++; $display("FAIL abort_latency got=%0d exp=%0d", o_lat, g.lat); end
  endtask

  task automatic test_arb;
    exp_t e;
    int n;
`ifdef SNOOP_RR_ARB_EN
    sbq.push_back('{done:4'b0001, dsel:4'b0010, search:4'b1110, inv:1'b0, lat:3, mem:0, tag:16'h0});
    sbq.push_back('{done:4'b0100, dsel:4'b0010, search:4'b1011, inv:1'b0, lat:3, mem:0, tag:16'h0});
    sbq.push_back('{done:4'b0001, dsel:4'b0010, search:4'b1110, inv:1'b0, lat:3, mem:0, tag:16'h0});
`else
    repeat (3) sbq.push_back('{done:4'b0001, dsel:4'b0010, search:4'b1110, inv:1'b0, lat:3, mem:0, tag:16'h0});
`endif
    @(negedge clk);
    bus.read_miss = 4'b0101;
    bus.cpu_search_found = 4'b0010;
    n = 0;
    for (int c = 0; c < 60 && n < 3; c++) begin
      @(negedge clk);
      if (bus.op_done != '0) begin
        e = sbq.pop_front();
        checks++; if (bus.op_done !== e.done) begin errors++; $display("FAIL arb_grant%0d got=%b exp=%b", n, bus.op_done, e.done); end
        n++;
      end
    end
    clear_req();
    checks++; if (n !== 3) begin errors++; $display("FAIL arb_count got=%0d exp=3", n); end
    sbq.delete();
  endtask

  task automatic test_reset_mid;
    exp_t g;
    bit seen;
    logic [4*N+2+TW-1:0] outs;
    @(negedge clk);
    bus.read_miss[3] = 1'b1;
    bus.req_tag[3*TW +: TW] = 16'hBEEF;
    bus.cpu_search_found = '0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (bus.mem_re) seen = 1;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rstmid_mem_entry got=%b exp=1", seen); end
    #2 rst_n = 1'b0;
    #1;
    outs = {bus.cpu_search, bus.cpu_datasel, bus.cpu_doing_curr_op, bus.op_done,
            bus.invalidate, bus.mem_re, bus.tag_out};
    checks++; if (outs !== '0) begin errors++; $display("FAIL rstmid_async got=%h exp=0", outs); end
    @(negedge clk);
    outs = {bus.cpu_search, bus.cpu_datasel, bus.cpu_doing_curr_op, bus.op_done,
            bus.invalidate, bus.mem_re, bus.tag_out};
    checks++; if (outs !== '0) begin errors++; $display("FAIL rstmid_held got=%h exp=0", outs); end
    @(negedge clk);
    rst_n = 1'b1;
    sbq.push_back('{done:4'b1000, dsel:4'b0000, search:4'b0111, inv:1'b0, lat:5, mem:2, tag:16'hBEEF});
    do_op(2'd3, 1, 0, 0, 16'hBEEF, 4'b0000, 2, 0, 0);
    g = sbq.pop_front();
    checks++; if (o_search !== g.search) begin errors++; $display("FAIL rstmid_rearb_search got=%b exp=%b", o_search, g.search); end
    checks++; if (o_tag !== g.tag) begin errors++; $display("FAIL rstmid_rearb_tag got=%h exp=%h", o_tag, g.tag); end
    checks++; if (o_lat !== g.lat) begin errors++; $display("FAIL rstmid_rearb_latency got=%0d exp=%0d", o_lat, g.lat); end
    checks++; if (o_done !== g.done) begin errors++; $display("FAIL rstmid_rearb_done got=%b exp=%b", o_done, g.done); end
  endtask

  initial begin
    test_reset();
    test_peer_hit();
    test_upgrade();
    test_mem_fill();
    test_own_found();
    test_rw_both();
    test_no_abort();
    test_arb();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/snoop_bus_arb.md
SNOOP_BUS_ARB -- requirements
Module: snoop_bus_arb

Interface
REQ-001 SHALL have parameter NUM_CPU, default 4, number of snooping cores (1..8).
REQ-002 SHALL have parameter TAG_W, default 16, width of the broadcast line tag.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 read_miss  input  NUM_CPU  per-core read-miss request, held until op_done.
REQ-007 write_miss  input  NUM_CPU  per-core write-miss request, held until op_done.
REQ-008 write_miss_state  input  NUM_CPU  1 = line already held shared (upgrade, invalidate only).
REQ-009 req_tag  input  NUM_CPU*TAG_W  per-core miss tag, core i at bits [i*TAG_W +: TAG_W].
REQ-010 cpu_search_found  input  NUM_CPU  peer holds the searched line valid.
REQ-011 mem_ack  input  1  memory fill complete.
REQ-012 tag_out  output  TAG_W  latched tag of the granted request.
REQ-013 cpu_search  output  NUM_CPU  snoop strobe to all non-granted cores.
REQ-014 cpu_datasel  output  NUM_CPU  one-hot supplier select for cache-to-cache transfer.
REQ-015 cpu_doing_curr_op  output  NUM_CPU  one-hot current grant.
REQ-016 invalidate  output  1  current snoop is a write (peers invalidate on hit).
REQ-017 mem_re  output  1  memory fill request.
REQ-018 op_done  output  NUM_CPU  one-cycle completion pulse to the granted core.

Function
REQ-019 SHALL implement FSM IDLE, SEARCH, RESP, MEM, DONE; all outputs registered.
REQ-020 IDLE: on any read_miss|write_miss bit, SHALL arbitrate, latch grant index, tag, op type, write_miss_state; next SEARCH.
REQ-021 Same core asserting read_miss and write_miss together SHALL be treated as a write miss.
REQ-022 SEARCH (1 cycle): cpu_search = ~grant, tag_out = latched tag, invalidate = write op; next RESP.
REQ-023 RESP: found bits SHALL be masked with ~grant; upgrade write -> DONE; masked hit -> cpu_datasel = lowest-index hitting peer for one cycle, then DONE; no hit -> MEM.
REQ-024 MEM: mem_re SHALL stay high until mem_ack sampled high; next DONE; mem_ack outside MEM ignored.
REQ-025 DONE: op_done[grant] high one cycle; arbitration pointer updated; next IDLE.
REQ-026 cpu_doing_curr_op SHALL be valid from SEARCH through DONE inclusive, zero in IDLE.
REQ-027 Latency: request sampled in IDLE cycle T -> op_done at T+3 (peer hit or upgrade); memory path -> op_done one cycle after mem_ack.
REQ-028 Request deassertion mid-operation SHALL NOT abort it; operation completes normally.
REQ-029 NUM_CPU=1 SHALL be legal: cpu_search always zero, every non-upgrade miss goes to MEM.

Reset
REQ-030 rst_n low SHALL force IDLE, all outputs 0, arbitration pointer 0, latched tag 0, immediately and at any FSM state.
REQ-031 After reset release, first arbitration SHALL occur on the first rising edge with a request present.

Configuration
REQ-032 Macro SNOOP_RR_ARB_EN defined: round-robin arbitration, search starts at index (last grant + 1) mod NUM_CPU.
REQ-033 SNOOP_RR_ARB_EN undefined: fixed priority, lowest index wins; pointer logic absent.

Verification
REQ-034 NUM_CPU=4; core 2 read_miss tag 0x1234, core 0 found=1 in RESP -> cpu_search=4'b1011, cpu_datasel=4'b0001, op_done=4'b0100 at T+3, mem_re never high.
REQ-035 Core 1 write_miss, write_miss_state=1 -> invalidate=1 in SEARCH, no datasel, no mem_re, op_done[1] at T+3.
REQ-036 Core 3 read_miss, no found, mem_ack 5 cycles after MEM entry -> mem_re high 5 cycles, op_done[3] the cycle after mem_ack.
REQ-037 Cores 0 and 2 request continuously with SNOOP_RR_ARB_EN -> grants alternate 0,2,0,2; without it -> grants 0,0,0.
REQ-038 rst_n low during MEM -> next edge all outputs 0, IDLE; pending request re-arbitrated after release.
REQ-039 Core 1 read_miss with its own found bit high only -> treated as miss, mem_re asserted.
